// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers: TXDATA, STATUS, BAUDDIV and TXCOUNT at BASE_ADDR..BASE_ADDR+3.
module mmio_uart_tx #(
    parameter logic [29:0] BASE_ADDR   = 30'h0,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] i_mmio_addr,
    input  logic [31:0] i_mmio_data,
    input  logic [3:0]  i_mmio_mask,
    input  logic        i_mmio_wren,
    output logic [31:0] o_mmio_data,
    output logic        o_tx
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e        state_q, state_d;
    logic          tx_q, tx_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [15:0]   timer_q, timer_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   div_q, div_d;
    logic [31:0]   txcount_q, txcount_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic [29:0] offset;
    logic        full, empty;
    logic        wr_txdata, wr_status, wr_div, wr_count;
    logic        push, pop, ovf_set, ovf_clr;
    logic        frame_done, tick;
    logic [15:0] eff_div, bit_load;
    logic [31:0] status;
    logic        unused_bits;

    assign unused_bits = ^{i_mmio_data[31:16], i_mmio_mask[3:2]};

    always_comb begin
        offset    = i_mmio_addr - BASE_ADDR;
        full      = (count_q == DEPTH_C);
        empty     = (count_q == '0);
        wr_txdata = i_mmio_wren && (offset == 30'd0);
        wr_status = i_mmio_wren && (offset == 30'd1);
        wr_div    = i_mmio_wren && (offset == 30'd2);
        wr_count  = i_mmio_wren && (offset == 30'd3);
        // Full is judged before this edge's pop, so a push while full drops.
        push      = wr_txdata && i_mmio_mask[0] && !full;
        ovf_set   = wr_txdata && i_mmio_mask[0] && full;
        ovf_clr   = wr_status && i_mmio_mask[0] && i_mmio_data[3];
        eff_div   = (div_q < 16'd2) ? 16'd2 : div_q;
        bit_load  = eff_div - 16'd1;
        tick      = (timer_q == 16'd0);
    end

    always_comb begin
        status = {19'b0, 5'(count_q), 4'b0,
                  ovf_q, empty, full, (state_q != IDLE)};
        o_mmio_data = 32'h0;
        case (offset)
            30'd1:   o_mmio_data = status;
            30'd2:   o_mmio_data = {16'h0, div_q};
            30'd3:   o_mmio_data = txcount_q;
            default: o_mmio_data = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        timer_d    = timer_q;
        pop        = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                    timer_d = bit_load;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    timer_d = bit_load;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    timer_d = bit_load;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    frame_done = 1'b1;
                    // Chain straight into the next start bit when data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                        timer_d = bit_load;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);

        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;

        div_d = div_q;
        if (wr_div && i_mmio_mask[0]) div_d[7:0]  = i_mmio_data[7:0];
        if (wr_div && i_mmio_mask[1]) div_d[15:8] = i_mmio_data[15:8];

        txcount_d = txcount_q + 32'(frame_done);
        if (wr_count) txcount_d = 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            shift_q   <= 8'h0;
            bit_q     <= 3'd0;
            timer_q   <= 16'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            div_q     <= DEFAULT_DIV;
            txcount_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            timer_q   <= timer_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            txcount_q <= txcount_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= i_mmio_data[7:0];
    end

    assign o_tx = tx_q;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Word-addressed MMIO responder for the core's MMIO port: address, write data, byte mask and write-enable in; read data out.
- Implements a buffered UART transmitter, 8N1, LSB first, idle high.
- Registers: TX data push, status, baud divisor and sent-byte counter.
- Sits at top level next to the CPU and drives one serial output pin.

Parameters:
- BASE_ADDR, 30'h0, word address of register 0. Registers occupy BASE_ADDR..BASE_ADDR+3.
- FIFO_DEPTH, 4, TX FIFO entries. Power of two, 2..16.
- DEFAULT_DIV, 16'd868, reset value of BAUDDIV in clocks per bit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_mmio_addr  in  30  word address from core
- i_mmio_data  in  32  write data
- i_mmio_mask  in  4  byte-lane write mask, bit k enables byte k
- i_mmio_wren  in  1  write strobe, sampled at posedge clk
- o_mmio_data  out  32  read data, combinational from i_mmio_addr
- o_tx  out  1  serial TX line, registered

Behaviour:
- Interface decision: one clock (clk); reset rst_n is synchronous and active-low. All state updates on posedge clk; rst_n sampled there.
- Reset values:
  - o_tx=1, FSM=IDLE, FIFO empty, BAUDDIV=DEFAULT_DIV, TXCOUNT=0, OVF=0.
  - o_mmio_data follows the decode below (STATUS reads 32'h4 after reset).
- Reset asserted mid-frame aborts the frame. o_tx is 1 from the next cycle and FIFO contents are discarded.
- Address decode: offset = i_mmio_addr - BASE_ADDR. Offsets outside 0..3 read 32'h0; writes to them are ignored.
- Reads have no side effects. o_mmio_data is valid in the same cycle as the address.
- Offset 0, TXDATA:
  - Write with mask[0]=1 pushes data[7:0] if the FIFO is not full.
  - If full, the byte is dropped and OVF is set.
  - Reads 0.
  - Full is evaluated from pre-edge state, so a push while full is dropped even if a pop occurs in the same cycle.
- Offset 1, STATUS (read):
  - bit0 BUSY (FSM != IDLE), bit1 FULL, bit2 EMPTY, bit3 OVF, bits[12:8] FIFO count, others 0.
  - Write with mask[0]=1 and data[3]=1 clears OVF (W1C).
  - If a set and a clear of OVF happen in the same cycle, set wins.
- Offset 2, BAUDDIV:
  - RW, bits[15:0]; bits[31:16] read 0.
  - Writes honor mask[1:0] per byte.
  - A stored value of 0 or 1 is used as 2 (minimum 2 clocks per bit); the register still reads back the written value.
  - A new value takes effect at the next bit boundary; the current bit completes with the old period.
- Offset 3, TXCOUNT:
  - 32-bit count of completed frames. Increments at the end of each stop bit and wraps 32'hFFFFFFFF->0.
  - Any write (any mask) clears it to 0.
  - If a write and an increment coincide, the clear wins.
- TX FSM:
  - States: IDLE, START, DATA, STOP. Bit timer counts down from eff_div-1; bit index 0..7.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, go to START, o_tx<=0.
  - START: after eff_div cycles, go to DATA, o_tx<=shift[0].
  - DATA: every eff_div cycles, shift right and output the next bit. After bit 7 has lasted eff_div cycles, go to STOP, o_tx<=1.
  - STOP: after eff_div cycles, increment TXCOUNT. If the FIFO is non-empty, pop, go to START and set o_tx<=0 in the same edge (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Latency:
  - A TXDATA write captured at edge N, into an empty FIFO with the FSM in IDLE, gives o_tx=0 from edge N+1.
  - Frame length is exactly 10*eff_div cycles.
- FIFO:
  - Circular pointers with wrap at FIFO_DEPTH and a count of 0..FIFO_DEPTH.
  - Simultaneous push and pop when not full and not empty leaves the count unchanged.
  - A push into an empty FIFO is not popped in the same cycle; the head is visible next cycle.

Test Plan:
- Reset, BAUDDIV=4, write 0x55 to TXDATA -> o_tx low from the next edge for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles. TXCOUNT=1, STATUS=32'h4 afterwards.
- BAUDDIV=2, write 0xA1,0xB2,0xC3 on consecutive cycles -> three contiguous frames totalling 60 cycles with no idle gap; TXCOUNT=3; BUSY=1 throughout.
- FIFO_DEPTH=4, BAUDDIV=100, push 6 bytes back-to-back -> first byte popped; count reaches 4, FULL=1; last byte dropped, OVF=1. Write STATUS 0x8 -> OVF=0; the 5 accepted bytes are transmitted in order.
- Mid-frame BAUDDIV write from 4 to 8 during DATA bit 3 -> bit 3 lasts 4 cycles; bits 4..7 and stop last 8 cycles each.
- rst_n low for 1 cycle during DATA with 2 bytes queued -> o_tx=1 next cycle; EMPTY=1, TXCOUNT=0, BAUDDIV=DEFAULT_DIV; no further frames.
- Read offsets 4 and BASE_ADDR-1 -> 0. Write TXCOUNT with mask 4'b0000 -> cleared. BAUDDIV write 0 -> reads 0, frame uses 2-cycle bits.
